dual7seg_rx: RTL

- Receiver/monitor for the multiplexed dual 7-segment bus driven by the two-digit counter display.
- Samples the active-low segment lines and the digit-select line, and waits for the segments to settle after each select toggle.
- Decodes each digit pattern back to BCD, then reassembles the tens/units pair into a binary value 0..99 with a one-cycle valid pulse.
- Used for on-board loopback self-test of the display path and as a scoreboard source in system benches.

---
 rtl/dual7seg_pkg.sv | 30 +++
 rtl/dual7seg_rx_seg_decode.sv | 29 ++
 rtl/dual7seg_rx.sv | 151 +++++++++++++++
 3 files changed

// File: rtl/dual7seg_pkg.sv
// Shared constants, FSM state type and BCD helper for the dual 7-segment receiver.
// Segment patterns are g..a in bits 6..0, active-high (1 = lit).
package dual7seg_pkg;

    localparam logic [6:0] SEG_0    = 7'b0111111;
    localparam logic [6:0] SEG_1    = 7'b0000110;
    localparam logic [6:0] SEG_2    = 7'b1011011;
    localparam logic [6:0] SEG_3    = 7'b1001111;
    localparam logic [6:0] SEG_4    = 7'b1100110;
    localparam logic [6:0] SEG_5    = 7'b1101101;
    localparam logic [6:0] SEG_6    = 7'b1111101;
    localparam logic [6:0] SEG_7    = 7'b0000111;
    localparam logic [6:0] SEG_8    = 7'b1111111;
    localparam logic [6:0] SEG_9    = 7'b1100111;
    localparam logic [6:0] SEG_DASH = 7'b1000000;

    typedef enum logic [1:0] {
        ST_WAIT_EDGE,
        ST_SETTLE,
        ST_CAPTURE
    } state_e;

    // tens*10 as shift-and-add; 99 is the largest result, so 7 bits suffice.
    function automatic logic [6:0] bcd_to_bin(input logic [3:0] tens, input logic [3:0] units);
        logic [6:0] t;
        t = {3'b000, tens};
        return (t << 3) + (t << 1) + {3'b000, units};
    endfunction

endpackage

// File: rtl/dual7seg_rx_seg_decode.sv
// Combinational 7-segment (active-high, g..a) to BCD decoder with a pattern-valid flag.
module seg_decode
    import dual7seg_pkg::*;
(
    input  logic [6:0] seg_i,
    output logic [3:0] digit_o,
    output logic       ok_o
);

    always_comb begin
        digit_o = '0;
        ok_o    = 1'b0;
        case (seg_i)
            SEG_0:    begin digit_o = 4'd0; ok_o = 1'b1; end
            SEG_1:    begin digit_o = 4'd1; ok_o = 1'b1; end
            SEG_2:    begin digit_o = 4'd2; ok_o = 1'b1; end
            SEG_3:    begin digit_o = 4'd3; ok_o = 1'b1; end
            SEG_4:    begin digit_o = 4'd4; ok_o = 1'b1; end
            SEG_5:    begin digit_o = 4'd5; ok_o = 1'b1; end
            SEG_6:    begin digit_o = 4'd6; ok_o = 1'b1; end
            SEG_7:    begin digit_o = 4'd7; ok_o = 1'b1; end
            SEG_8:    begin digit_o = 4'd8; ok_o = 1'b1; end
            SEG_9:    begin digit_o = 4'd9; ok_o = 1'b1; end
            SEG_DASH: begin digit_o = 4'd0; ok_o = 1'b0; end
            default:  begin digit_o = 4'd0; ok_o = 1'b0; end
        endcase
    end

endmodule

// File: rtl/dual7seg_rx.sv
// Receiver for the multiplexed dual 7-segment bus: synchronizes, waits for the
// segments to settle after each select edge, decodes both digits and emits 0..99.
module dual7seg_rx
    import dual7seg_pkg::*;
#(
    parameter int unsigned SETTLE   = 4,
    parameter int unsigned TIMEOUT  = 1000000,
    parameter logic        SEL_TENS = 1'b0
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic [6:0] i_seg,
    input  logic       i_sel,
    output logic [6:0] o_value,
    output logic [3:0] o_tens,
    output logic [3:0] o_units,
    output logic       o_valid,
    output logic       o_err,
    output logic       o_stale
);

    localparam int unsigned SW = $clog2(SETTLE + 1);
    localparam int unsigned TW = $clog2(TIMEOUT + 1);

    logic [6:0]    seg_s1_q, seg_s2_q, seg_prev_q;
    logic          sel_s1_q, sel_s2_q, sel_prev_q;
    state_e        state_q;
    logic          slot_tens_q;
    logic          tens_seen_q;
    logic [3:0]    pend_tens_q;
    logic          pend_ok_q;
    logic [SW-1:0] settle_cnt_q, settle_cnt_d, settle_inc;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;
    logic [6:0]    value_q;
    logic [3:0]    tens_q, units_q;
    logic          valid_q, err_q;

    logic          sel_edge;
    logic          seg_stable;
    logic          settle_done;
    logic [3:0]    dec_digit;
    logic          dec_ok;

    assign sel_edge   = sel_s2_q ^ sel_prev_q;
    assign seg_stable = (seg_s2_q == seg_prev_q);

    seg_decode u_seg_decode (
        .seg_i   (~seg_s2_q),
        .digit_o (dec_digit),
        .ok_o    (dec_ok)
    );

    always_comb begin
        settle_inc   = settle_cnt_q + SW'(1);
        settle_cnt_d = settle_cnt_q;
        if (sel_edge) begin
            settle_cnt_d = '0;
        end else if (state_q == ST_SETTLE) begin
            settle_cnt_d = seg_stable ? settle_inc : '0;
        end
        settle_done = (state_q == ST_SETTLE) && !sel_edge && seg_stable
                      && (settle_inc == SW'(SETTLE));
    end

    always_comb begin
        tmo_cnt_d = tmo_cnt_q;
        if (sel_edge) begin
            tmo_cnt_d = '0;
        end else if (tmo_cnt_q != TW'(TIMEOUT)) begin
            tmo_cnt_d = tmo_cnt_q + TW'(1);
        end
    end

    // A select edge takes priority in every state, including CAPTURE, so a select
    // period shorter than SETTLE+2 never lets a slot reach capture.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            seg_s1_q     <= '0;
            seg_s2_q     <= '0;
            seg_prev_q   <= '0;
            sel_s1_q     <= 1'b0;
            sel_s2_q     <= 1'b0;
            sel_prev_q   <= 1'b0;
            state_q      <= ST_WAIT_EDGE;
            slot_tens_q  <= 1'b0;
            tens_seen_q  <= 1'b0;
            pend_tens_q  <= '0;
            pend_ok_q    <= 1'b0;
            settle_cnt_q <= '0;
            tmo_cnt_q    <= '0;
            value_q      <= '0;
            tens_q       <= '0;
            units_q      <= '0;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            seg_s1_q     <= i_seg;
            seg_s2_q     <= seg_s1_q;
            seg_prev_q   <= seg_s2_q;
            sel_s1_q     <= i_sel;
            sel_s2_q     <= sel_s1_q;
            sel_prev_q   <= sel_s2_q;
            settle_cnt_q <= settle_cnt_d;
            tmo_cnt_q    <= tmo_cnt_d;
            valid_q      <= 1'b0;
            err_q        <= 1'b0;

            if (sel_edge) begin
                state_q     <= ST_SETTLE;
                slot_tens_q <= (sel_s2_q == SEL_TENS);
            end else begin
                case (state_q)
                    ST_WAIT_EDGE: state_q <= ST_WAIT_EDGE;
                    ST_SETTLE: begin
                        if (settle_done) state_q <= ST_CAPTURE;
                    end
                    ST_CAPTURE: begin
                        state_q <= ST_WAIT_EDGE;
                        if (slot_tens_q) begin
                            pend_tens_q <= dec_digit;
                            pend_ok_q   <= dec_ok;
                            tens_seen_q <= 1'b1;
                        end else if (!tens_seen_q) begin
                            pend_tens_q <= '0;
                            pend_ok_q   <= 1'b0;
                        end else begin
                            tens_seen_q <= 1'b0;
                            if (pend_ok_q && dec_ok) begin
                                value_q <= bcd_to_bin(pend_tens_q, dec_digit);
                                tens_q  <= pend_tens_q;
                                units_q <= dec_digit;
                                valid_q <= 1'b1;
                            end else begin
                                err_q   <= 1'b1;
                            end
                        end
                    end
                    default: state_q <= ST_WAIT_EDGE;
                endcase
            end
        end
    end

    assign o_value = value_q;
    assign o_tens  = tens_q;
    assign o_units = units_q;
    assign o_valid = valid_q;
    assign o_err   = err_q;
    assign o_stale = (tmo_cnt_q == TW'(TIMEOUT));

endmodule
